// File: rtl/jvm_mem_pkg.sv
// Shared types and constants for the multi-port JVM memory block.
// Optional feature macro: JVM_MEM_WAIT_EN (address-dependent wait states).
package jvm_mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int WAIT_W         = 2;
   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_DEPTH  = 256;

endpackage

// File: rtl/jvm_mem_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the lowest requester at or after the
// pointer; the pointer moves past the granted channel whenever a grant is taken.
module jvm_mem_rr_arbiter #(
   parameter int NPORT = 2,
   parameter int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NPORT-1:0] req,
   input  logic             advance,
   output logic [NPORT-1:0] grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] ptr;
   logic [NPORT-1:0] upper;
   logic [NPORT-1:0] pick;

   // Requests at or above the pointer win; otherwise wrap to the lowest request.
   always_comb begin
      upper = '0;
      for (int i = 0; i < NPORT; i++) begin
         upper[i] = req[i] && (i >= int'(ptr));
      end
      pick      = (|upper) ? upper : req;
      grant     = pick & (~pick + NPORT'(1));
      grant_idx = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (grant[i]) begin
            grant_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (advance && (|grant)) begin
         ptr <= (grant_idx == IDX_W'(NPORT - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/jvm_mem_multiport.sv
// Multi-channel word memory with byte-enabled writes, one access in flight at a time.
// Define JVM_MEM_WAIT_EN to add addr[1:0] wait cycles per access.
module jvm_mem_multiport
   import jvm_mem_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = 8,
   parameter int NPORT  = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NPORT-1:0]           start,
   input  logic [NPORT-1:0]           rwn,
   input  logic [NPORT*ADDR_W-1:0]    addr,
   input  logic [NPORT*DATA_W-1:0]    wdata,
   input  logic [NPORT*DATA_W/8-1:0]  be,
   output logic [NPORT*DATA_W-1:0]    rdata,
   output logic [NPORT-1:0]           ready,
   output logic [NPORT-1:0]           err
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_t            state;
   logic [NPORT-1:0]  pending;
   logic [NPORT-1:0]  req_rwn;
   logic [ADDR_W-1:0] req_addr  [NPORT];
   logic [DATA_W-1:0] req_wdata [NPORT];
   logic [BE_W-1:0]   req_be    [NPORT];
   logic [DATA_W-1:0] rdata_r   [NPORT];
   logic [IDX_W-1:0]  cur;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [NPORT-1:0]  grant;
   logic [IDX_W-1:0]  grant_idx;
   logic              do_grant;
   logic              do_access;
   logic              wait_done;
   logic              cur_in_range;
   logic [DATA_W-1:0] merged;

   assign ready        = ~pending;
   assign do_grant     = (state == IDLE) && (|grant);
   assign do_access    = (state == BUSY) && wait_done;
   assign cur_in_range = {1'b0, req_addr[cur]} < DEPTH_EXT;

   for (genvar g = 0; g < NPORT; g++) begin : g_rdata
      assign rdata[g*DATA_W +: DATA_W] = rdata_r[g];
   end

   jvm_mem_rr_arbiter #(
      .NPORT (NPORT),
      .IDX_W (IDX_W)
   ) u_arbiter (
      .clk       (clk),
      .reset     (reset),
      .req       (pending),
      .advance   (state == IDLE),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

`ifdef JVM_MEM_WAIT_EN
   logic [WAIT_W-1:0] wait_cnt;

   assign wait_done = (wait_cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (do_grant) begin
         wait_cnt <= req_addr[grant_idx][WAIT_W-1:0];
      end else if ((state == BUSY) && !wait_done) begin
         wait_cnt <= wait_cnt - WAIT_W'(1);
      end
   end
`else
   assign wait_done = 1'b1;
`endif

   // Byte-merge of the in-flight write into the currently stored word.
   always_comb begin
      merged = mem[req_addr[cur]];
      for (int b = 0; b < BE_W; b++) begin
         if (req_be[cur][b]) begin
            merged[b*8 +: 8] = req_wdata[cur][b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_access && !req_rwn[cur] && cur_in_range) begin
         mem[req_addr[cur]] <= merged;
      end
   end

   // Per-channel request capture plus the IDLE/BUSY access sequencer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cur     <= '0;
         pending <= '0;
         req_rwn <= '0;
         err     <= '0;
         for (int p = 0; p < NPORT; p++) begin
            req_addr[p]  <= '0;
            req_wdata[p] <= '0;
            req_be[p]    <= '0;
            rdata_r[p]   <= '0;
         end
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            if (start[p] && !pending[p]) begin
               pending[p]   <= 1'b1;
               req_rwn[p]   <= rwn[p];
               req_addr[p]  <= addr[p*ADDR_W +: ADDR_W];
               req_wdata[p] <= wdata[p*DATA_W +: DATA_W];
               req_be[p]    <= be[p*BE_W +: BE_W];
               err[p]       <= 1'b0;
            end
         end
         case (state)
            IDLE: begin
               if (do_grant) begin
                  cur   <= grant_idx;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (wait_done) begin
                  pending[cur] <= 1'b0;
                  err[cur]     <= !cur_in_range;
                  if (req_rwn[cur]) begin
                     rdata_r[cur] <= cur_in_range ? mem[req_addr[cur]] : '0;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jvm_mem_multiport.sv
// Directed self-checking bench for jvm_mem_multiport (DEPTH=200, two channels).
// Expected latencies follow JVM_MEM_WAIT_EN when it is defined.
module tb_jvm_mem_multiport;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 200;
   localparam int ADDR_W = 8;
   localparam int NPORT  = 2;
`ifdef JVM_MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic [NPORT-1:0]          start = '0;
   logic [NPORT-1:0]          rwn = '0;
   logic [NPORT*ADDR_W-1:0]   addr = '0;
   logic [NPORT*DATA_W-1:0]   wdata = '0;
   logic [NPORT*DATA_W/8-1:0] be = '0;
   logic [NPORT*DATA_W-1:0]   rdata;
   logic [NPORT-1:0]          ready;
   logic [NPORT-1:0]          err;

   int checks = 0;
   int errors = 0;
   int lat0;
   int lat1;

   jvm_mem_multiport #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NPORT  (NPORT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .rwn   (rwn),
      .addr  (addr),
      .wdata (wdata),
      .be    (be),
      .rdata (rdata),
      .ready (ready),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic int lat_of(input logic [7:0] a);
      return 2 + (WAIT_EN ? int'(a[1:0]) : 0);
   endfunction

   task automatic drive(input int ch, input logic rd, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
      rwn[ch]           = rd;
      addr[ch*8 +: 8]   = a;
      wdata[ch*32 +: 32] = d;
      be[ch*4 +: 4]     = b;
   endtask

   // One request on one channel; returns how many sampled cycles ready stayed low.
   task automatic apply_stimulus(input int ch, input logic rd, input logic [7:0] a, input logic [31:0] d,
                                 input logic [3:0] b, output int lat);
      @(negedge clk);
      drive(ch, rd, a, d, b);
      start[ch] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[ch] = 1'b0;
      lat = 0;
      while (!ready[ch] && lat < 60) begin
         lat++;
         @(negedge clk);
      end
   endtask

   // Both channels request on the same edge with full byte enables.
   task automatic apply_pair(input logic rd0, input logic [7:0] a0, input logic [31:0] d0,
                             input logic rd1, input logic [7:0] a1, input logic [31:0] d1,
                             output int l0, output int l1);
      @(negedge clk);
      drive(0, rd0, a0, d0, 4'hF);
      drive(1, rd1, a1, d1, 4'hF);
      start = 2'b11;
      @(posedge clk);
      @(negedge clk);
      start = 2'b00;
      l0 = 0;
      l1 = 0;
      for (int n = 0; n < 60 && ready != 2'b11; n++) begin
         if (!ready[0]) l0++;
         if (!ready[1]) l1++;
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_output("reset_ready", 32'(ready), 32'h3);
      check_output("reset_rdata0", rdata[31:0], 32'h0);
      check_output("reset_rdata1", rdata[63:32], 32'h0);
      check_output("reset_err", 32'(err), 32'h0);
      reset = 1'b1;

      apply_stimulus(0, 1'b0, 8'd5, 32'hDEADBEEF, 4'hF, lat0);
      check_output("wr5_lat", 32'(lat0), 32'(lat_of(8'd5)));
      check_output("wr5_err", 32'(err[0]), 32'h0);
      apply_stimulus(0, 1'b1, 8'd5, 32'h0, 4'h0, lat0);
      check_output("rd5_lat", 32'(lat0), 32'(lat_of(8'd5)));
      check_output("rd5_data", rdata[31:0], 32'hDEADBEEF);

      apply_stimulus(0, 1'b0, 8'd7, 32'h11223344, 4'hF, lat0);
      apply_stimulus(0, 1'b0, 8'd7, 32'hAABBCCDD, 4'h5, lat0);
      check_output("rdata0_held", rdata[31:0], 32'hDEADBEEF);
      apply_stimulus(0, 1'b1, 8'd7, 32'h0, 4'h0, lat0);
      check_output("rd7_merge", rdata[31:0], 32'h11BB33DD);

      apply_stimulus(1, 1'b0, 8'd7, 32'hFFFFFFFF, 4'h0, lat1);
      check_output("be0_lat", 32'(lat1), 32'(lat_of(8'd7)));
      apply_stimulus(1, 1'b1, 8'd7, 32'h0, 4'h0, lat1);
      check_output("be0_noop", rdata[63:32], 32'h11BB33DD);

      apply_pair(1'b0, 8'd1, 32'h000000A5, 1'b1, 8'd1, 32'h0, lat0, lat1);
      check_output("coll1_lat0", 32'(lat0), 32'(lat_of(8'd1)));
      check_output("coll1_lat1", 32'(lat1), 32'(2 * lat_of(8'd1)));
      check_output("coll1_rd1", rdata[63:32], 32'h000000A5);

      apply_stimulus(0, 1'b1, 8'd1, 32'h0, 4'h0, lat0);
      check_output("rd1_ch0", rdata[31:0], 32'h000000A5);
      apply_pair(1'b0, 8'd2, 32'h00000077, 1'b1, 8'd2, 32'h0, lat0, lat1);
      check_output("coll2_lat1", 32'(lat1), 32'(lat_of(8'd2)));
      check_output("coll2_lat0", 32'(lat0), 32'(2 * lat_of(8'd2)));
      check_output("coll2_rd1_old", rdata[63:32], 32'h0);
      apply_stimulus(1, 1'b1, 8'd2, 32'h0, 4'h0, lat1);
      check_output("rd2_new", rdata[63:32], 32'h00000077);

      apply_stimulus(1, 1'b1, 8'd250, 32'h0, 4'h0, lat1);
      check_output("oor_rd_data", rdata[63:32], 32'h0);
      check_output("oor_rd_err", 32'(err[1]), 32'h1);
      check_output("oor_rd_lat", 32'(lat1), 32'(lat_of(8'd250)));
      apply_stimulus(1, 1'b0, 8'd199, 32'hCAFEF00D, 4'hF, lat1);
      check_output("edge199_err", 32'(err[1]), 32'h0);
      apply_stimulus(1, 1'b0, 8'd200, 32'h12345678, 4'hF, lat1);
      check_output("oor200_err", 32'(err[1]), 32'h1);
      apply_stimulus(1, 1'b1, 8'd199, 32'h0, 4'h0, lat1);
      check_output("rd199_data", rdata[63:32], 32'hCAFEF00D);
      check_output("rd199_err", 32'(err[1]), 32'h0);

      // Abort a write to addr 3 after its grant edge.
      @(negedge clk);
      drive(0, 1'b0, 8'd3, 32'h12345678, 4'hF);
      start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("midrst_ready", 32'(ready), 32'h3);
      check_output("midrst_rdata", rdata[31:0] | rdata[63:32], 32'h0);
      @(negedge clk);
      reset = 1'b1;
      apply_stimulus(0, 1'b1, 8'd3, 32'h0, 4'h0, lat0);
      check_output("post_rst_rd3", rdata[31:0], 32'h0);
      check_output("post_rst_lat", 32'(lat0), 32'(lat_of(8'd3)));
      apply_stimulus(1, 1'b1, 8'd5, 32'h0, 4'h0, lat1);
      check_output("post_rst_rd5", rdata[63:32], 32'h0);
      check_output("post_rst_ready", 32'(ready), 32'h3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
